// File: rtl/exe_div_unit.sv
// exe_div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU in EXE.
// Produces one quotient bit per clock; quotient goes to LO, remainder to HI.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for a DIV/DIVU in EXE; stall only while accepting
//   BUSY  | iterating, one quotient bit per edge; pipeline frozen
//   DONE  | one-cycle result-valid pulse; instruction leaves EXE after it
module exe_div_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              EXE_DivStart,
    input  logic              EXE_DivSigned,
    input  logic [DATA_W-1:0] EXE_Dividend,
    input  logic [DATA_W-1:0] EXE_Divisor,
    input  logic              EXE_Flush,
    output logic              Div_Stall,
    output logic              Div_Busy,
    output logic              Div_Done,
    output logic [DATA_W-1:0] Div_Quotient,
    output logic [DATA_W-1:0] Div_Remainder
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    state_e             state_q, state_d;
    // dvd_q shifts the dividend magnitude out at the MSB while quotient
    // bits shift in at the LSB, so after the last iteration it holds |Q|.
    logic [DATA_W-1:0]  dvd_q, dvd_d;
    logic [DATA_W-1:0]  dvs_q, dvs_d;
    logic [DATA_W-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic [DATA_W-1:0]  quo_res_q, quo_res_d;
    logic [DATA_W-1:0]  rem_res_q, rem_res_d;

    logic               dvd_neg, dvs_neg;
    logic [DATA_W-1:0]  dvd_mag, dvs_mag;
    logic [DATA_W:0]    rem_shift;
    logic               rem_ge;
    logic [DATA_W-1:0]  rem_iter, quo_iter;
    logic [DATA_W-1:0]  quo_fix, rem_fix;
    logic               last_iter;

    // Operand magnitudes and one restoring step. The shifted remainder is
    // DATA_W+1 bits wide: with an unsigned divisor above 2^(DATA_W-1) the
    // shifted partial remainder can exceed DATA_W bits before subtraction.
    always_comb begin
        dvd_neg   = EXE_DivSigned & EXE_Dividend[DATA_W-1];
        dvs_neg   = EXE_DivSigned & EXE_Divisor[DATA_W-1];
        dvd_mag   = dvd_neg ? (~EXE_Dividend + ONE) : EXE_Dividend;
        dvs_mag   = dvs_neg ? (~EXE_Divisor + ONE) : EXE_Divisor;
        rem_shift = {rem_q, dvd_q[DATA_W-1]};
        rem_ge    = (rem_shift >= {1'b0, dvs_q});
        rem_iter  = rem_ge ? (rem_shift[DATA_W-1:0] - dvs_q) : rem_shift[DATA_W-1:0];
        quo_iter  = {dvd_q[DATA_W-2:0], rem_ge};
        quo_fix   = neg_quo_q ? (~quo_iter + ONE) : quo_iter;
        rem_fix   = neg_rem_q ? (~rem_iter + ONE) : rem_iter;
        last_iter = (cnt_q == CNT_W'(DATA_W - 1));
    end

    // Next-state and datapath updates; flush overrides everything and
    // leaves the result registers untouched.
    always_comb begin
        state_d   = state_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        quo_res_d = quo_res_q;
        rem_res_d = rem_res_q;

        if (EXE_Flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (EXE_DivStart) begin
                        dvd_d     = dvd_mag;
                        dvs_d     = dvs_mag;
                        rem_d     = '0;
                        cnt_d     = '0;
                        neg_quo_d = dvd_neg ^ dvs_neg;
                        neg_rem_d = dvd_neg;
                        state_d   = BUSY;
                    end
                end
                BUSY: begin
                    dvd_d = quo_iter;
                    rem_d = rem_iter;
                    cnt_d = cnt_q + 1'b1;
                    if (last_iter) begin
                        quo_res_d = quo_fix;
                        rem_res_d = rem_fix;
                        state_d   = DONE;
                    end
                end
                DONE: begin
                    // Start is still high from the finishing instruction;
                    // returning to IDLE unconditionally prevents a relaunch.
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, iteration datapath and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            quo_res_q <= '0;
            rem_res_q <= '0;
        end else begin
            state_q   <= state_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            quo_res_q <= quo_res_d;
            rem_res_q <= rem_res_d;
        end
    end

    // Pipeline-facing status; stall is combinational so the accepting cycle
    // is already frozen, and it drops in DONE to let the instruction advance.
    always_comb begin
        Div_Busy      = (state_q == BUSY);
        Div_Done      = (state_q == DONE) & ~EXE_Flush;
        Div_Stall     = ((state_q == IDLE) & EXE_DivStart & ~EXE_Flush) | (state_q == BUSY);
        Div_Quotient  = quo_res_q;
        Div_Remainder = rem_res_q;
    end

endmodule

// File: tb/tb_exe_div_unit.sv
// Directed bench for exe_div_unit: hand-computed DIV/DIVU vectors, timing,
// flush, mid-operation reset and start-held-through-done behaviour.
module tb_exe_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        div_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] quo;
    logic [31:0] rem;

    int n_checks = 0;
    int n_errors = 0;

    exe_div_unit #(
        .DATA_W(32),
        .CNT_W (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .EXE_DivStart (start),
        .EXE_DivSigned(div_signed),
        .EXE_Dividend (dividend),
        .EXE_Divisor  (divisor),
        .EXE_Flush    (flush),
        .Div_Stall    (stall),
        .Div_Busy     (busy),
        .Div_Done     (done),
        .Div_Quotient (quo),
        .Div_Remainder(rem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at #1 after an edge with the DUT idle. Start is held through
    // the Done cycle, as the finishing instruction would, and dropped after.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_q,
                           input logic [31:0] exp_r);
        int n;
        int stall_n;
        bit seen;
        div_signed = sgn;
        dividend   = a;
        divisor    = b;
        start      = 1'b1;
        #1;
        check_eq({tag, " stall_accept"}, {31'b0, stall}, 32'd1);
        n       = 0;
        stall_n = 0;
        seen    = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (done) seen = 1'b1;
            else if (stall) stall_n++;
        end
        check_eq({tag, " latency"}, n, 32'd33);
        check_eq({tag, " stall_cycles"}, stall_n, 32'd32);
        check_eq({tag, " stall_in_done"}, {31'b0, stall}, 32'd0);
        check_eq({tag, " quotient"}, quo, exp_q);
        check_eq({tag, " remainder"}, rem, exp_r);
        @(posedge clk); #1;
        check_eq({tag, " busy_after"}, {31'b0, busy}, 32'd0);
        check_eq({tag, " done_once"}, {31'b0, done}, 32'd0);
        start = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        div_signed = 1'b0;
        dividend   = '0;
        divisor    = '0;
        flush      = 1'b0;
        #1;
        check_eq("rst quotient",  quo, 32'h0);
        check_eq("rst remainder", rem, 32'h0);
        check_eq("rst busy",  {31'b0, busy},  32'd0);
        check_eq("rst done",  {31'b0, done},  32'd0);
        check_eq("rst stall", {31'b0, stall}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'h0000000E, 32'h00000002);

        // Flush at iteration 10 with Start still high: abort, no Done,
        // results from the previous divide stay put.
        div_signed = 1'b0;
        dividend   = 32'h00001234;
        divisor    = 32'd5;
        start      = 1'b1;
        @(posedge clk); #1;
        check_eq("flush busy_started", {31'b0, busy}, 32'd1);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        #1;
        check_eq("flush done_gated", {31'b0, done}, 32'd0);
        @(posedge clk); #1;
        check_eq("flush busy_cleared", {31'b0, busy}, 32'd0);
        check_eq("flush done", {31'b0, done}, 32'd0);
        check_eq("flush quotient_kept",  quo, 32'h0000000E);
        check_eq("flush remainder_kept", rem, 32'h00000002);
        flush = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);

        run_div("div_m7_2",      1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF);
        run_div("div_7_m2",      1'b1, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001);
        run_div("div_min_m1",    1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000);
        run_div("divu_7_0",      1'b0, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 32'h00000007);
        run_div("div_m7_0",      1'b1, 32'hFFFFFFF9, 32'h00000000, 32'h00000001, 32'hFFFFFFF9);
        run_div("divu_big_dvs",  1'b0, 32'hFFFFFFFF, 32'h80000001, 32'h00000001, 32'h7FFFFFFE);

        // Flush and Start together in IDLE: flush wins, nothing launches.
        div_signed = 1'b0;
        dividend   = 32'd50;
        divisor    = 32'd5;
        start      = 1'b1;
        flush      = 1'b1;
        #1;
        check_eq("flush_vs_start stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        check_eq("flush_vs_start busy", {31'b0, busy}, 32'd0);
        start = 1'b0;
        flush = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of BUSY clears everything immediately.
        div_signed = 1'b0;
        dividend   = 32'h0000FFFF;
        divisor    = 32'd3;
        start      = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        check_eq("midrst busy_before", {31'b0, busy}, 32'd1);
        start = 1'b0;
        rst   = 1'b1;
        #1;
        check_eq("midrst quotient",  quo, 32'h0);
        check_eq("midrst remainder", rem, 32'h0);
        check_eq("midrst busy",  {31'b0, busy},  32'd0);
        check_eq("midrst done",  {31'b0, done},  32'd0);
        check_eq("midrst stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_div("divu_after_rst", 1'b0, 32'd100, 32'd7, 32'h0000000E, 32'h00000002);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
